sm_adder_sequencer: RTL and testbench
=====================================

# sm_adder_sequencer

Operator-driven sequencer for the shared 4-bit sign-magnitude adder on the board test path. It debounces the two push buttons and latches operand A, then operand B, from the slide switches. It then launches one addition on the external combinational adder, waits a programmable settling time, and captures the result. It also drives the value and the mode indicator consumed by the hex/sign display path.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 500000 — consecutive stable synchronized samples required to accept a button level change (≥2); counter width is clog2(DEBOUNCE_CYCLES+1).
- ADD_WAIT, 1 — cycles spent in ADD before capturing the adder output (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- sw  in  4  operand switches, sign-magnitude: bit3 = sign, [2:0] = magnitude.
- btn  in  2  raw active-high buttons: btn[0] = ENTER, btn[1] = CLEAR.
- add_a  out  4  operand A register to adder.
- add_b  out  4  operand B register to adder.
- add_res  in  4  adder result, sign-magnitude.
- add_start  out  1  one-cycle strobe marking launch of an addition.
- busy  out  1  high while in ADD.
- res_valid  out  1  captured result valid.
- disp_val  out  4  value for display path.
- disp_sel  out  2  mode: 00 entering A, 01 entering B, 10 result, 11 unused.

## Operation
- Each btn bit passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer counter clears whenever the synchronized level equals the stable level.
  - It increments while they differ.
  - When it would reach DEBOUNCE_CYCLES, the stable level flips and the counter clears.
- Press event: registered one-cycle pulse on a rising edge of the stable level. Releases generate no event.
- FSM states: ENTER_A, ENTER_B, ADD, SHOW.
  - ENTER_A: disp_val = sw (live), disp_sel = 00. ENTER event → add_a ← sw, go to ENTER_B.
  - ENTER_B: disp_val = sw, disp_sel = 01. ENTER event → add_b ← sw, wait counter ← ADD_WAIT, go to ADD.
  - ADD: busy = 1, disp_val = 0000, disp_sel = 01. The counter decrements each cycle. When the counter reads 1:
    - capture add_res into the result register;
    - if add_res = 1000 (negative zero), store 0000 instead;
    - set res_valid and go to SHOW.
    - ENTER events in ADD are ignored.
  - SHOW: disp_val = result, disp_sel = 10. ENTER event → clear res_valid, go to ENTER_A. add_a and add_b are retained until overwritten.
- CLEAR event in any state:
  - go to ENTER_A;
  - add_a, add_b and the result register ← 0000, res_valid ← 0;
  - in ADD, this aborts the addition and add_res is not captured.
- CLEAR and ENTER events in the same cycle: CLEAR wins and ENTER is discarded.
- The block performs no arithmetic itself; sign and magnitude pass through unmodified except for the negative-zero normalization.

## Timing
- Reset values, asynchronous on reset = 0:
  - state = ENTER_A;
  - add_a = add_b = 0000, add_start = 0, busy = 0, res_valid = 0;
  - disp_sel = 00, disp_val = sw (combinational);
  - synchronizers, stable levels, counters and event pulses all 0.
- Release of reset is sampled on the next rising edge. Reset mid-ADD returns to ENTER_A with no capture and no add_start.
- Button latency: the event pulse is high for exactly one cycle, DEBOUNCE_CYCLES+3 edges after the first edge that samples btn high.
- The state transition and operand latch occur on the edge where the event is high.
- add_start: registered, high during the first cycle in ADD only.
- busy: high for exactly ADD_WAIT cycles.
- res_valid and SHOW begin the cycle after the last ADD cycle.
- add_a and add_b are stable throughout ADD.
- Holding a button yields exactly one event. Each subsequent event requires a release that is itself debounced.

## Test plan
Bench parameters: DEBOUNCE_CYCLES = 4, ADD_WAIT = 2; the bench models the adder.

- **Reset:** assert reset mid-run → all outputs as listed above, disp_sel = 00, disp_val tracks sw = 0101.
- **Debounce rejection and latency:**
  - btn[0] high for 3 cycles, then low → no event, state ENTER_A.
  - btn[0] held high → exactly one event at edge 7; state ENTER_B.
- **Normal add:** sw = 0011 ENTER, sw = 1010 ENTER, model returns add_res = 0001 →
  - add_a = 0011, add_b = 1010;
  - add_start high for 1 cycle, busy high for 2 cycles;
  - then res_valid = 1, disp_val = 0001, disp_sel = 10.
- **Negative zero:** A = 0010, B = 1010, model returns 1000 → disp_val = 0000, res_valid = 1.
- **CLEAR during ADD:** press CLEAR while busy = 1 →
  - ENTER_A, add_a = add_b = 0000, res_valid stays 0;
  - a later add_res change has no effect.
- **Simultaneous CLEAR + ENTER in ENTER_B:** → ENTER_A, add_b not loaded, no add_start.
- **SHOW → ENTER:** in SHOW, ENTER → res_valid = 0, state ENTER_A, add_a retains the prior value.

Source files
------------

// File: rtl/sm_adder_sequencer_if.sv
// Operand/result bus between the sequencer and the external
// sign-magnitude adder.
interface sm_adder_sequencer_if;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] add_res;
    logic       add_start;
    logic       busy;
    logic       res_valid;

    modport master (
        output add_a,
        output add_b,
        output add_start,
        output busy,
        output res_valid,
        input  add_res
    );

    modport slave (
        input  add_a,
        input  add_b,
        input  add_start,
        input  busy,
        input  res_valid,
        output add_res
    );
endinterface

// File: rtl/sm_adder_sequencer.sv
// Button-driven operand entry, launch and capture sequencer for an
// external 4-bit sign-magnitude adder, plus display mode outputs.
module sm_adder_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ADD_WAIT        = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [3:0]                  sw,
    input  logic [1:0]                  btn,
    sm_adder_sequencer_if.master        add,
    output logic [3:0]                  disp_val,
    output logic [1:0]                  disp_sel
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int WW = $clog2(ADD_WAIT + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_INIT = WW'(ADD_WAIT);
    localparam logic [WW-1:0] WAIT_LAST = WW'(1);

    typedef enum logic [1:0] {
        S_ENTER_A,
        S_ENTER_B,
        S_ADD,
        S_SHOW
    } state_e;

    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    logic [1:0]    stab_q;
    logic [1:0]    ev_q;
    logic [CW-1:0] cnt_q [2];

    // Event fires on the same edge the stable level rises.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stab_q   <= '0;
            ev_q     <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                ev_q[i] <= 1'b0;
                if (sync2_q[i] == stab_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == DB_LAST) begin
                    stab_q[i] <= sync2_q[i];
                    cnt_q[i]  <= '0;
                    ev_q[i]   <= sync2_q[i];
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    state_e        state_q, state_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    b_q, b_d;
    logic [3:0]    res_q, res_d;
    logic          rv_q, rv_d;
    logic          start_q, start_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          enter;
    logic          clear;

    assign clear = ev_q[1];
    assign enter = ev_q[0] & ~ev_q[1];

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        rv_d     = rv_q;
        wait_d   = wait_q;
        start_d  = 1'b0;
        disp_val = sw;
        disp_sel = 2'b00;
        unique case (state_q)
            S_ENTER_A: begin
                if (enter) begin
                    a_d     = sw;
                    state_d = S_ENTER_B;
                end
            end
            S_ENTER_B: begin
                disp_sel = 2'b01;
                if (enter) begin
                    b_d     = sw;
                    wait_d  = WAIT_INIT;
                    start_d = 1'b1;
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                disp_val = 4'b0000;
                disp_sel = 2'b01;
                if (wait_q == WAIT_LAST) begin
                    // Negative zero is folded to plain zero.
                    res_d   = (add.add_res == 4'b1000) ? 4'b0000 : add.add_res;
                    rv_d    = 1'b1;
                    state_d = S_SHOW;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            S_SHOW: begin
                disp_val = res_q;
                disp_sel = 2'b10;
                if (enter) begin
                    rv_d    = 1'b0;
                    state_d = S_ENTER_A;
                end
            end
            default: ;
        endcase
        if (clear) begin
            state_d = S_ENTER_A;
            a_d     = 4'b0000;
            b_d     = 4'b0000;
            res_d   = 4'b0000;
            rv_d    = 1'b0;
            start_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_ENTER_A;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            start_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            start_q <= start_d;
            wait_q  <= wait_d;
        end
    end

    assign add.add_a     = a_q;
    assign add.add_b     = b_q;
    assign add.add_start = start_q;
    assign add.busy      = (state_q == S_ADD);
    assign add.res_valid = rv_q;
endmodule

// File: tb/tb_sm_adder_sequencer.sv
// Directed bench for sm_adder_sequencer with a behavioural
// sign-magnitude adder and a result scoreboard.
module tb_sm_adder_sequencer;
    logic       clk;
    logic       reset;
    logic [3:0] sw;
    logic [1:0] btn;
    logic [3:0] disp_val;
    logic [1:0] disp_sel;
    logic       ovr_en;
    logic [3:0] ovr_val;
    bit         nz_mode;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    logic [3:0] exp_q [$];

    sm_adder_sequencer_if bus ();

    sm_adder_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .ADD_WAIT       (2)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .btn     (btn),
        .add     (bus.master),
        .disp_val(disp_val),
        .disp_sel(disp_sel)
    );

    function automatic logic [3:0] smadd(input logic [3:0] a,
                                         input logic [3:0] b,
                                         input bit nz);
        int va, vb, s;
        va = a[3] ? -int'(a[2:0]) : int'(a[2:0]);
        vb = b[3] ? -int'(b[2:0]) : int'(b[2:0]);
        s  = va + vb;
        if (s == 0) return nz ? 4'b1000 : 4'b0000;
        if (s < 0) return {1'b1, 3'(-s)};
        return {1'b0, 3'(s)};
    endfunction

    function automatic logic [3:0] norm(input logic [3:0] x);
        return (x == 4'b1000) ? 4'b0000 : x;
    endfunction

    assign bus.add_res = ovr_en ? ovr_val
                                : smadd(bus.add_a, bus.add_b, nz_mode);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int idx);
        btn[idx] = 1'b1;
        repeat (7) tick;
        btn[idx] = 1'b0;
    endtask

    task automatic settle;
        repeat (8) tick;
    endtask

    task automatic wait_result;
        int k;
        k = 0;
        while (!bus.res_valid && k < 10) begin
            tick;
            k++;
        end
        chk("rv_seen", 8'(bus.res_valid), 8'd1);
        if (exp_q.size() > 0) chk("sb_result", 8'(disp_val), 8'(exp_q.pop_front()));
        else chk("sb_underflow", 8'(exp_q.size()), 8'd1);
    endtask

    initial begin
        btn     = 2'b00;
        sw      = 4'b0101;
        reset   = 1'b0;
        ovr_en  = 1'b0;
        ovr_val = 4'b0000;
        nz_mode = 1'b0;
        repeat (2) tick;
        chk("rst_sel", 8'(disp_sel), 8'h0);
        chk("rst_val", 8'(disp_val), 8'h5);
        chk("rst_a", 8'(bus.add_a), 8'h0);
        chk("rst_b", 8'(bus.add_b), 8'h0);
        chk("rst_start", 8'(bus.add_start), 8'h0);
        chk("rst_busy", 8'(bus.busy), 8'h0);
        chk("rst_rv", 8'(bus.res_valid), 8'h0);
        reset = 1'b1;
        tick;

        btn = 2'b01;
        repeat (3) tick;
        btn = 2'b00;
        repeat (10) tick;
        chk("rej_sel", 8'(disp_sel), 8'h0);

        sw  = 4'b0011;
        btn = 2'b01;
        repeat (6) tick;
        chk("lat_edge6", 8'(disp_sel), 8'h0);
        tick;
        chk("lat_edge7", 8'(disp_sel), 8'h1);
        chk("lat_a", 8'(bus.add_a), 8'h3);
        repeat (10) tick;
        chk("hold_one_event", 8'(disp_sel), 8'h1);
        btn = 2'b00;
        settle;

        sw = 4'b1010;
        exp_q.push_back(norm(smadd(4'b0011, 4'b1010, 1'b0)));
        press(0);
        chk("add_start1", 8'(bus.add_start), 8'h1);
        chk("add_busy1", 8'(bus.busy), 8'h1);
        chk("add_a", 8'(bus.add_a), 8'h3);
        chk("add_b", 8'(bus.add_b), 8'ha);
        chk("add_dval", 8'(disp_val), 8'h0);
        tick;
        chk("add_start2", 8'(bus.add_start), 8'h0);
        chk("add_busy2", 8'(bus.busy), 8'h1);
        chk("add_rv2", 8'(bus.res_valid), 8'h0);
        wait_result;
        chk("show_busy", 8'(bus.busy), 8'h0);
        chk("show_sel", 8'(disp_sel), 8'h2);
        chk("show_dval", 8'(disp_val), 8'h1);
        settle;

        press(0);
        chk("show_exit_rv", 8'(bus.res_valid), 8'h0);
        chk("show_exit_sel", 8'(disp_sel), 8'h0);
        chk("show_exit_a", 8'(bus.add_a), 8'h3);
        settle;

        sw = 4'b0010;
        press(0);
        settle;
        sw      = 4'b1010;
        nz_mode = 1'b1;
        exp_q.push_back(norm(smadd(4'b0010, 4'b1010, 1'b1)));
        press(0);
        wait_result;
        chk("nz_dval", 8'(disp_val), 8'h0);
        chk("nz_sel", 8'(disp_sel), 8'h2);
        nz_mode = 1'b0;
        settle;

        press(1);
        chk("clr_show_sel", 8'(disp_sel), 8'h0);
        chk("clr_show_rv", 8'(bus.res_valid), 8'h0);
        chk("clr_show_a", 8'(bus.add_a), 8'h0);
        settle;

        sw = 4'b0001;
        press(0);
        settle;
        btn = 2'b01;
        tick;
        btn = 2'b11;
        repeat (6) tick;
        chk("clr_add_busy", 8'(bus.busy), 8'h1);
        btn = 2'b00;
        tick;
        chk("clr_add_sel", 8'(disp_sel), 8'h0);
        chk("clr_add_busy0", 8'(bus.busy), 8'h0);
        chk("clr_add_a", 8'(bus.add_a), 8'h0);
        chk("clr_add_b", 8'(bus.add_b), 8'h0);
        chk("clr_add_rv", 8'(bus.res_valid), 8'h0);
        ovr_en  = 1'b1;
        ovr_val = 4'b0111;
        repeat (12) tick;
        chk("clr_add_late_rv", 8'(bus.res_valid), 8'h0);
        chk("clr_add_late_sel", 8'(disp_sel), 8'h0);
        ovr_en = 1'b0;

        sw = 4'b0110;
        press(0);
        settle;
        sw  = 4'b0111;
        btn = 2'b11;
        repeat (7) tick;
        btn = 2'b00;
        chk("both_sel", 8'(disp_sel), 8'h0);
        chk("both_b", 8'(bus.add_b), 8'h0);
        chk("both_start", 8'(bus.add_start), 8'h0);
        chk("both_busy", 8'(bus.busy), 8'h0);
        settle;

        sw = 4'b0011;
        press(0);
        settle;
        sw = 4'b0001;
        press(0);
        chk("mid_busy", 8'(bus.busy), 8'h1);
        sw    = 4'b0101;
        reset = 1'b0;
        #1;
        chk("mid_rst_sel", 8'(disp_sel), 8'h0);
        chk("mid_rst_val", 8'(disp_val), 8'h5);
        chk("mid_rst_a", 8'(bus.add_a), 8'h0);
        chk("mid_rst_b", 8'(bus.add_b), 8'h0);
        chk("mid_rst_start", 8'(bus.add_start), 8'h0);
        chk("mid_rst_busy", 8'(bus.busy), 8'h0);
        chk("mid_rst_rv", 8'(bus.res_valid), 8'h0);
        repeat (2) tick;
        reset = 1'b1;
        repeat (3) tick;
        chk("post_rst_rv", 8'(bus.res_valid), 8'h0);
        chk("post_rst_sel", 8'(disp_sel), 8'h0);

        chk("sb_drained", 8'(exp_q.size()), 8'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
